// File: rtl/spi_ram_ctrl.sv
// Command decoder and 8-bit RAM behind an SPI slave: address-latch, write and
// read commands arrive as 10-bit words qualified by a level-held rx_valid.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    state_t               state;
    logic                 rx_prev;
    logic                 rst_block;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_set;
    logic                 rd_addr_set;
    logic [7:0]           mem [MEM_DEPTH];

    logic                 accept;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] payload_addr;

    assign opcode       = din[9:8];
    assign payload_addr = din[ADDR_SIZE-1:0];

    // rst_block keeps an rx_valid that was already high at reset release from
    // looking like a fresh edge until it has been seen low at least once.
    assign accept = (state == IDLE) && rx_valid && !rx_prev && !rst_block;

    always_ff @(posedge clk) begin
        if (!rst && accept && opcode == OP_WR_DATA && wr_addr_set)
            mem[wr_addr] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx_prev     <= 1'b0;
            rst_block   <= 1'b1;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_set <= 1'b0;
            rd_addr_set <= 1'b0;
            dout        <= 8'h00;
            tx_valid    <= 1'b0;
            err         <= 1'b0;
        end else begin
            rx_prev <= rx_valid;
            err     <= 1'b0;
            if (!rx_valid)
                rst_block <= 1'b0;

            case (state)
                IDLE: if (accept) state <= EXEC;
                EXEC: state <= rx_valid ? HOLD : IDLE;
                HOLD: if (!rx_valid) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (accept) begin
                tx_valid <= 1'b0;
                case (opcode)
                    OP_WR_ADDR: begin
                        wr_addr     <= payload_addr;
                        wr_addr_set <= 1'b1;
                    end
                    OP_WR_DATA: begin
                        if (!wr_addr_set)
                            err <= 1'b1;
                        else if (AUTO_INC != 0)
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                    end
                    OP_RD_ADDR: begin
                        rd_addr     <= payload_addr;
                        rd_addr_set <= 1'b1;
                    end
                    OP_RD_DATA: begin
                        if (!rd_addr_set) begin
                            err <= 1'b1;
                        end else begin
                            dout     <= mem[rd_addr];
                            tx_valid <= 1'b1;
                            if (AUTO_INC != 0)
                                rd_addr <= rd_addr + ADDR_SIZE'(1);
                        end
                    end
                    default: err <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: one instance without and one with
// address auto-increment, driven from a command table plus reset corner cases.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din0, din1;
    logic       rx0, rx1;
    logic [7:0] dout0, dout1;
    logic       tx0, tx1, err0, err1;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .rx_valid(rx0),
        .dout(dout0), .tx_valid(tx0), .err(err0)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .rx_valid(rx1),
        .dout(dout1), .tx_valid(tx1), .err(err1)
    );

    typedef struct {
        logic       err;
        logic       tx;
        logic [7:0] dout;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [1:0] op;
        logic [7:0] pay;
        int         hold;
        logic       e_err;
        logic       e_tx;
        logic [7:0] e_dout;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t sample(input bit sel);
        exp_t s;
        s.err  = sel ? err1  : err0;
        s.tx   = sel ? tx1   : tx0;
        s.dout = sel ? dout1 : dout0;
        return s;
    endfunction

    task automatic drive(input bit sel, input logic [9:0] d, input logic v);
        if (sel) begin din1 = d; rx1 = v; end
        else     begin din0 = d; rx0 = v; end
    endtask

    // One command: rx_valid high for 'hold' cycles, then low for one cycle.
    task automatic cmd(input bit sel, input logic [1:0] op, input logic [7:0] pay,
                       input int hold, input exp_t e);
        exp_t got, want;
        sb.push_back(e);
        @(negedge clk);
        drive(sel, {op, pay}, 1'b1);
        @(posedge clk); #1;
        got  = sample(sel);
        want = sb.pop_front();
        check("err",      {7'd0, got.err}, {7'd0, want.err});
        check("tx_valid", {7'd0, got.tx},  {7'd0, want.tx});
        check("dout",     got.dout,        want.dout);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk); #1;
            got = sample(sel);
            check("held_no_err", {7'd0, got.err}, 8'd0);
            check("held_dout",   got.dout,        want.dout);
        end
        @(negedge clk);
        drive(sel, {op, pay}, 1'b0);
        @(posedge clk); #1;
        got = sample(sel);
        check("err_one_cycle", {7'd0, got.err}, 8'd0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        drive(1'b0, 10'd0, 1'b0);
        drive(1'b1, 10'd0, 1'b0);

        // non-incrementing instance
        vecs.push_back('{1'b0, 2'b11, 8'h00,  1, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'b01, 8'h33,  1, 1'b1, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'b00, 8'h12,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'b01, 8'hA5,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'b10, 8'h12,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'hA5});
        vecs.push_back('{1'b0, 2'b11, 8'hFF,  1, 1'b0, 1'b1, 8'hA5});
        vecs.push_back('{1'b0, 2'b00, 8'h01,  1, 1'b0, 1'b0, 8'hA5});
        vecs.push_back('{1'b0, 2'b00, 8'h07,  1, 1'b0, 1'b0, 8'hA5});
        vecs.push_back('{1'b0, 2'b01, 8'h5A, 12, 1'b0, 1'b0, 8'hA5});
        vecs.push_back('{1'b0, 2'b10, 8'h07,  1, 1'b0, 1'b0, 8'hA5});
        vecs.push_back('{1'b0, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h5A});
        vecs.push_back('{1'b0, 2'b00, 8'h20,  1, 1'b0, 1'b0, 8'h5A});
        vecs.push_back('{1'b0, 2'b10, 8'h20,  1, 1'b0, 1'b0, 8'h5A});
        vecs.push_back('{1'b0, 2'b01, 8'hC3,  1, 1'b0, 1'b0, 8'h5A});
        vecs.push_back('{1'b0, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'hC3});
        vecs.push_back('{1'b0, 2'b01, 8'h3C,  1, 1'b0, 1'b0, 8'hC3});
        vecs.push_back('{1'b0, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h3C});
        vecs.push_back('{1'b0, 2'b00, 8'h40,  1, 1'b0, 1'b0, 8'h3C});
        vecs.push_back('{1'b0, 2'b01, 8'h77,  1, 1'b0, 1'b0, 8'h3C});
        vecs.push_back('{1'b0, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h3C});
        // auto-incrementing instance
        vecs.push_back('{1'b1, 2'b00, 8'h01,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'b01, 8'h33,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'b00, 8'hFF,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'b01, 8'h11,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'b01, 8'h22,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'b10, 8'hFF,  1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h11});
        vecs.push_back('{1'b1, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h22});
        vecs.push_back('{1'b1, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h33});
        vecs.push_back('{1'b1, 2'b10, 8'h00,  1, 1'b0, 1'b0, 8'h33});
        vecs.push_back('{1'b1, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'h22});
        vecs.push_back('{1'b1, 2'b00, 8'h50,  1, 1'b0, 1'b0, 8'h22});
        vecs.push_back('{1'b1, 2'b01, 8'hAB,  6, 1'b0, 1'b0, 8'h22});
        vecs.push_back('{1'b1, 2'b01, 8'hCD,  1, 1'b0, 1'b0, 8'h22});
        vecs.push_back('{1'b1, 2'b10, 8'h50,  1, 1'b0, 1'b0, 8'h22});
        vecs.push_back('{1'b1, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'hAB});
        vecs.push_back('{1'b1, 2'b11, 8'h00,  1, 1'b0, 1'b1, 8'hCD});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_dout0", dout0, 8'h00);
        check("rst_tx0",   {7'd0, tx0},  8'd0);
        check("rst_err0",  {7'd0, err0}, 8'd0);
        check("rst_dout1", dout1, 8'h00);
        check("rst_tx1",   {7'd0, tx1},  8'd0);
        check("rst_err1",  {7'd0, err1}, 8'd0);

        foreach (vecs[i]) begin
            e.err  = vecs[i].e_err;
            e.tx   = vecs[i].e_tx;
            e.dout = vecs[i].e_dout;
            cmd(vecs[i].sel, vecs[i].op, vecs[i].pay, vecs[i].hold, e);
        end

        // Reset coincident with a write acceptance, rx_valid held across release.
        @(negedge clk);
        drive(1'b0, {2'b01, 8'h99}, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstcmd_dout", dout0, 8'h00);
        check("rstcmd_tx",   {7'd0, tx0},  8'd0);
        check("rstcmd_err",  {7'd0, err0}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("blocked_no_err", {7'd0, err0}, 8'd0);
            check("blocked_no_tx",  {7'd0, tx0},  8'd0);
        end
        @(negedge clk);
        drive(1'b0, {2'b01, 8'h99}, 1'b0);
        @(posedge clk);

        e = '{1'b1, 1'b0, 8'h00};
        cmd(1'b0, 2'b01, 8'h99, 1, e);
        e = '{1'b0, 1'b0, 8'h00};
        cmd(1'b0, 2'b10, 8'h40, 1, e);
        e = '{1'b0, 1'b1, 8'h77};
        cmd(1'b0, 2'b11, 8'h00, 1, e);

        check("scoreboard_empty", 8'(sb.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 Parameter AUTO_INC, default 0; when 1, addresses SHALL post-increment after each data operation.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  10  command word from SPI slave; [9:8] opcode, [7:0] payload.
REQ-007 rx_valid  input  1  level-held valid from SPI slave; din stable while high.
REQ-008 dout  output  8  read data to SPI slave, registered.
REQ-009 tx_valid  output  1  dout valid for SPI slave transmission, registered.
REQ-010 err  output  1  one-cycle pulse on illegal command sequence, registered.

Function
REQ-011 A command SHALL be accepted only on a rising edge of rx_valid (rx_valid=1 this cycle, 0 previous cycle); a held-high rx_valid SHALL NOT re-execute.
REQ-012 Opcode 00 SHALL load wr_addr <= din[7:0] and set wr_addr_set.
REQ-013 Opcode 01 with wr_addr_set=1 SHALL write mem[wr_addr] <= din[7:0] on the accepting edge.
REQ-014 Opcode 10 SHALL load rd_addr <= din[7:0] and set rd_addr_set.
REQ-015 Opcode 11 with rd_addr_set=1 SHALL load dout <= mem[rd_addr] and tx_valid <= 1 on the accepting edge (visible 1 cycle after acceptance); din[7:0] ignored.
REQ-016 Opcode 01 with wr_addr_set=0, or 11 with rd_addr_set=0, SHALL assert err for exactly one cycle with no memory, address or dout change.
REQ-017 Address-set flags SHALL remain set after data operations; repeated data ops to a latched address are legal.
REQ-018 tx_valid SHALL stay high until the next accepted command of any opcode, which SHALL clear it on its accepting edge unless that command is a legal opcode 11, which reloads dout and keeps tx_valid high.
REQ-019 dout SHALL hold its last value when tx_valid clears.
REQ-020 AUTO_INC=1: after a legal 01 (11), wr_addr (rd_addr) SHALL increment by 1 modulo MEM_DEPTH; MEM_DEPTH-1 wraps to 0.
REQ-021 Opcode 01 followed by 11 to the same address SHALL return the newly written data.
REQ-022 Control SHALL be a 3-state FSM: IDLE (waiting for edge), EXEC (one cycle, decode/execute), HOLD (rx_valid still high, awaiting its fall); IDLE->EXEC on edge, EXEC->HOLD if rx_valid=1 else IDLE, HOLD->IDLE when rx_valid=0; execution SHALL occur on the accepting edge as REQ-011.
REQ-023 rx_valid low for one cycle between commands SHALL suffice for acceptance of the next command.

Reset
REQ-024 rst=1 at a rising edge SHALL set dout=0, tx_valid=0, err=0, wr_addr=0, rd_addr=0, both set flags=0, FSM=IDLE, rx_valid history=0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 rst SHALL dominate any simultaneous command; rx_valid held high across reset release SHALL count as a new rising edge only after it first falls.

Verification
REQ-027 Reset; 00_0x12 then 01_0xA5 then 10_0x12 then 11_xx -> tx_valid=1, dout=0xA5 one cycle after 4th acceptance.
REQ-028 After reset, 11_xx -> err=1 for one cycle, tx_valid=0, dout=0x00; 01_0x33 -> err pulse, no write.
REQ-029 rx_valid held high 12 cycles with 01_0x5A after 00_0x07 -> exactly one write; mem[7]=0x5A, no err.
REQ-030 AUTO_INC=1: 00_0xFF, 01_0x11, 01_0x22; 10_0xFF, 11, 11 -> dout 0x11 then 0x22, mem[0]=0x22, rd_addr=0x01.
REQ-031 tx_valid high, then 00_0x01 accepted -> tx_valid=0, dout retains prior value.
REQ-032 rst asserted during EXEC of 01 with rx_valid held high -> no write, outputs zero, no command until rx_valid falls and rises.
